// File: rtl/bank_byte_reader.sv
// rtl/bank_byte_reader.sv - turns random-access reads of the four-bank byte mux into a handshaked byte burst
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   start, start_addr,      burst request (accepted only when idle), first byte
//   length                  address {bank, byte}, and byte count
//   abort                   cancels the current burst (no done pulse)
//   mux_data                combinational data_out of the bank mux
//   bank_sel, byte_sel      registered selects driven into the bank mux
//   byte_out, byte_valid,   captured byte stream toward the consumer
//   byte_ready
//   busy, done              not idle / one-cycle pulse at normal completion
module bank_byte_reader #(
  parameter int LEN_W = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [3:0]       start_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  input  logic [7:0]       mux_data,
  output logic [1:0]       bank_sel,
  output logic [1:0]       byte_sel,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      rem_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    byte_d  = byte_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = start_addr;
            rem_d   = length;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      // Selects were registered on the previous edge, so mux_data has settled.
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          byte_d  = mux_data;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end

      // Abort wins over a simultaneous handshake; byte_out and selects are left alone.
      S_OUT: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (byte_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + 4'd1;  // wraps 15 -> 0
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_LOAD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bank_sel   = addr_q[3:2];
  assign byte_sel   = addr_q[1:0];
  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_bank_byte_reader.sv
// tb/tb_bank_byte_reader.sv - scoreboard bench for bank_byte_reader with a behavioural bank model
module tb_bank_byte_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_addr = 4'd0;
  logic [4:0] length = 5'd0;
  logic       abort = 1'b0;
  logic [7:0] mux_data;
  logic [1:0] bank_sel, byte_sel;
  logic [7:0] byte_out;
  logic       byte_valid, byte_ready, busy, done;

  logic rdy_mode = 1'b0;
  logic rdy_man  = 1'b1;
  logic rdy_rand = 1'b0;
  assign byte_ready = rdy_mode ? rdy_rand : rdy_man;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] bank_w [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};

  always_comb mux_data = 8'(bank_w[bank_sel] >> {byte_sel, 3'b000});

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  bank_byte_reader #(.LEN_W(5)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .abort     (abort),
    .mux_data  (mux_data),
    .bank_sel  (bank_sel),
    .byte_sel  (byte_sel),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_byte(input int a);
    int m;
    m = a % 16;
    return 8'(bank_w[m / 4] >> (8 * (m % 4)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte, checks hold stability, counts done pulses.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    exp_t       e;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (byte_valid && prev_stall) chk("byte_stable", 32'(byte_out), 32'(prev_byte));
        if (byte_valid && byte_ready && !abort) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(byte_out), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", 32'(byte_out), 32'(e.data));
            chk("byte_addr", 32'({bank_sel, byte_sel}), 32'(e.addr));
          end
        end
        prev_stall = byte_valid && !(byte_ready && !abort);
        prev_byte  = byte_out;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] a, input logic [4:0] l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    length     = l;
    for (int i = 0; i < int'(l); i++) exp_q.push_back('{addr: 4'((int'(a) + i) % 16), data: model_byte(int'(a) + i)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!byte_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!byte_valid) chk("wait_valid_timeout", 32'(byte_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    int exp_d;
    int ab_at;
    logic do_abort;
    logic [3:0] ra;
    logic [4:0] rl;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sel", 32'({bank_sel, byte_sel}), 0);
    chk("rst_byte", 32'(byte_out), 0);
    rst = 1'b0;

    // Straight 4-byte burst with the consumer always ready
    rdy_mode = 1'b0;
    rdy_man  = 1'b1;
    d0 = done_cnt;
    issue(4'd0, 5'd4);
    chk("t1_load_valid", 32'(byte_valid), 0);
    chk("t1_load_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    chk("t1_first_valid", 32'(byte_valid), 1);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_done_seen", 32'(done), 1);
    @(posedge clk);
    #1;
    chk("t1_busy_after_done", 32'(busy), 0);
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_drain", 32'(exp_q.size()), 0);
    chk("t1_done_count", 32'(done_cnt - d0), 1);

    // Address wrap from bank 3 byte 2
    d0 = done_cnt;
    issue(4'd14, 5'd3);
    wait_idle();
    chk("t2_drain", 32'(exp_q.size()), 0);
    chk("t2_done_count", 32'(done_cnt - d0), 1);

    // Consumer stalls the first byte for 5 cycles
    d0 = done_cnt;
    rdy_man = 1'b0;
    issue(4'd5, 5'd2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", 32'(byte_valid), 1);
      chk("t3_stall_byte", 32'(byte_out), 32'h66);
      @(posedge clk);
      #1;
    end
    rdy_man = 1'b1;
    wait_idle();
    chk("t3_drain", 32'(exp_q.size()), 0);
    chk("t3_done_count", 32'(done_cnt - d0), 1);

    // Zero-length request
    d0 = done_cnt;
    issue(4'd3, 5'd0);
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_valid", 32'(byte_valid), 0);
    @(posedge clk);
    #1;
    chk("t4_done_after", 32'(done), 0);
    chk("t4_busy_after", 32'(busy), 0);
    chk("t4_done_count", 32'(done_cnt - d0), 1);

    // Abort on the third byte, with a stray start while busy and ready high during abort
    d0 = done_cnt;
    rdy_man = 1'b0;
    issue(4'd0, 5'd8);
    start      = 1'b1;
    start_addr = 4'd12;
    length     = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_valid();
      rdy_man = 1'b1;
      @(posedge clk);
      #1;
      rdy_man = 1'b0;
    end
    wait_valid();
    abort   = 1'b1;
    rdy_man = 1'b1;
    @(posedge clk);
    #1;
    abort   = 1'b0;
    rdy_man = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_valid", 32'(byte_valid), 0);
    chk("t5_abort_done", 32'(done), 0);
    chk("t5_abort_byte_kept", 32'(byte_out), 32'(model_byte(2)));
    chk("t5_abort_sel_kept", 32'({bank_sel, byte_sel}), 2);
    chk("t5_abort_leftover", 32'(exp_q.size()), 6);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    rdy_man = 1'b1;
    issue(4'd9, 5'd3);
    wait_idle();
    chk("t5_restart_drain", 32'(exp_q.size()), 0);
    chk("t5_restart_done", 32'(done_cnt - d0), 1);

    // Asynchronous reset between edges while a byte is waiting
    d0 = done_cnt;
    rdy_man = 1'b0;
    issue(4'd7, 5'd4);
    wait_valid();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(byte_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_sel", 32'({bank_sel, byte_sel}), 0);
    chk("t6_rst_byte", 32'(byte_out), 0);
    chk("t6_rst_done", 32'(done), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt - d0), 0);

    // Randomized bursts, random consumer backpressure, occasional abort
    rdy_mode = 1'b1;
    for (int b = 0; b < 40; b++) begin
      ra       = 4'($urandom_range(0, 15));
      rl       = 5'($urandom_range(0, 20));
      do_abort = ($urandom_range(0, 4) == 0);
      ab_at    = $urandom_range(1, 12);
      d0       = done_cnt;
      exp_d    = 1;
      issue(ra, rl);
      n = 1;
      while (busy && n < 2000) begin
        if (do_abort && n == ab_at) begin
          exp_d = done ? 1 : 0;
          abort = 1'b1;
          @(posedge clk);
          #1;
          abort = 1'b0;
          exp_q.delete();
        end else begin
          @(posedge clk);
          #1;
        end
        n++;
      end
      if (busy) chk("rand_timeout", 32'(busy), 0);
      chk("rand_done_count", 32'(done_cnt - d0), 32'(exp_d));
      chk("rand_drain", 32'(exp_q.size()), 0);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
